// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared defaults and stage-entry type for the destination-register scoreboard.
package reg_dest_scoreboard_pkg;

    localparam int NREGS_DEF      = 32;
    localparam int AW_DEF         = 5;
    localparam int PIPE_DEPTH_DEF = 3;

    localparam logic [AW_DEF-1:0] R0_ADDR = '0;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] dest;
    } stage_t;

endpackage

// File: rtl/reg_dest_scoreboard_dest_decoder.sv
// Address-to-one-hot register decoder, output all-zero when disabled.
// Latency: combinational. Backpressure: none.
module dest_decoder #(
    parameter int NREGS = reg_dest_scoreboard_pkg::NREGS_DEF,
    parameter int AW    = reg_dest_scoreboard_pkg::AW_DEF
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// In-flight destination tracking: PENDING vector, RAW STALL, one-hot write-back enable.
// Latency: write-back PIPE_DEPTH-1 cycles after an entry first appears; STALL holds issue off.
// Optional macro WB_BYPASS_EN: the write-back stage does not cause a stall.
module reg_dest_scoreboard
    import reg_dest_scoreboard_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int AW         = AW_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ISSUE_VALID,
    input  logic             ISSUE_WEN,
    input  logic [AW-1:0]    ISSUE_DEST,
    input  logic [AW-1:0]    SRC_A,
    input  logic [AW-1:0]    SRC_B,
    input  logic             SRC_A_USED,
    input  logic             SRC_B_USED,
    input  logic             FLUSH,
    output logic             STALL,
    output logic [NREGS-1:0] PENDING,
    output logic             WB_VALID,
    output logic [AW-1:0]    WB_DEST,
    output logic [NREGS-1:0] WB_ONEHOT
);

    stage_t           stg    [PIPE_DEPTH];
    logic [NREGS-1:0] stg_oh [PIPE_DEPTH];
    logic [NREGS-1:0] pend_all;
    logic [NREGS-1:0] pend_hit;
    logic             hit_a;
    logic             hit_b;
    logic             accept;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage_dec
        dest_decoder #(.NREGS(NREGS), .AW(AW)) u_dec (
            .addr   (stg[g].dest),
            .en     (stg[g].valid),
            .onehot (stg_oh[g])
        );
    end

    dest_decoder #(.NREGS(NREGS), .AW(AW)) u_wb_dec (
        .addr   (stg[PIPE_DEPTH-1].dest),
        .en     (stg[PIPE_DEPTH-1].valid),
        .onehot (WB_ONEHOT)
    );

    always_comb begin
        pend_all = '0;
        pend_hit = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            pend_all = pend_all | stg_oh[i];
`ifdef WB_BYPASS_EN
            // Write-back stage is forwarded, so a consumer may issue alongside it.
            if (i != PIPE_DEPTH-1) pend_hit = pend_hit | stg_oh[i];
`else
            pend_hit = pend_hit | stg_oh[i];
`endif
        end
    end

    assign hit_a    = SRC_A_USED && (SRC_A != R0_ADDR) && pend_hit[SRC_A];
    assign hit_b    = SRC_B_USED && (SRC_B != R0_ADDR) && pend_hit[SRC_B];
    assign STALL    = ISSUE_VALID && (hit_a || hit_b);
    assign accept   = ISSUE_VALID && ISSUE_WEN && (ISSUE_DEST != R0_ADDR) && !STALL && !FLUSH;

    assign PENDING  = {pend_all[NREGS-1:1], 1'b0};
    assign WB_VALID = stg[PIPE_DEPTH-1].valid;
    assign WB_DEST  = stg[PIPE_DEPTH-1].dest;

    // Bubbles carry dest 0 so WB_DEST reads 0 whenever WB_VALID is low.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg[i] <= '0;
        end else begin
            for (int i = PIPE_DEPTH-1; i > 0; i--) stg[i] <= stg[i-1];
            stg[0].valid <= accept;
            stg[0].dest  <= accept ? ISSUE_DEST : R0_ADDR;
        end
    end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Randomized bench comparing the scoreboard against an age-list model of in-flight writes.
module tb_reg_dest_scoreboard;

    localparam int D = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ISSUE_VALID = 1'b0;
    logic        ISSUE_WEN = 1'b0;
    logic [4:0]  ISSUE_DEST = '0;
    logic [4:0]  SRC_A = '0;
    logic [4:0]  SRC_B = '0;
    logic        SRC_A_USED = 1'b0;
    logic        SRC_B_USED = 1'b0;
    logic        FLUSH = 1'b0;
    logic        STALL;
    logic [31:0] PENDING;
    logic        WB_VALID;
    logic [4:0]  WB_DEST;
    logic [31:0] WB_ONEHOT;

    reg_dest_scoreboard #(.NREGS(32), .AW(5), .PIPE_DEPTH(D)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_WEN   (ISSUE_WEN),
        .ISSUE_DEST  (ISSUE_DEST),
        .SRC_A       (SRC_A),
        .SRC_B       (SRC_B),
        .SRC_A_USED  (SRC_A_USED),
        .SRC_B_USED  (SRC_B_USED),
        .FLUSH       (FLUSH),
        .STALL       (STALL),
        .PENDING     (PENDING),
        .WB_VALID    (WB_VALID),
        .WB_DEST     (WB_DEST),
        .WB_ONEHOT   (WB_ONEHOT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // In-flight writes: destination plus number of edges since acceptance.
    int m_dest[$];
    int m_age[$];

    logic [31:0] e_pend;
    logic [31:0] e_oh;
    logic        e_wbv;
    logic [4:0]  e_wbd;
    logic        e_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        logic [31:0] hitset;
        hitset = '0;
        e_pend = '0;
        e_oh   = '0;
        e_wbv  = 1'b0;
        e_wbd  = '0;
        foreach (m_dest[k]) begin
            e_pend[m_dest[k]] = 1'b1;
            if (m_age[k] == D-1) begin
                e_wbv = 1'b1;
                e_wbd = 5'(m_dest[k]);
                e_oh  = 32'd1 << m_dest[k];
            end
`ifdef WB_BYPASS_EN
            if (m_age[k] != D-1) hitset[m_dest[k]] = 1'b1;
`else
            hitset[m_dest[k]] = 1'b1;
`endif
        end
        e_stall = ISSUE_VALID &&
                  ((SRC_A_USED && SRC_A != 0 && hitset[SRC_A]) ||
                   (SRC_B_USED && SRC_B != 0 && hitset[SRC_B]));
    endtask

    task automatic model_step();
        int  nd[$];
        int  na[$];
        logic acc;
        if (RST || FLUSH) begin
            m_dest.delete();
            m_age.delete();
        end else begin
            acc = ISSUE_VALID && ISSUE_WEN && ISSUE_DEST != 0 && !e_stall;
            foreach (m_dest[k]) begin
                if (m_age[k] + 1 < D) begin
                    nd.push_back(m_dest[k]);
                    na.push_back(m_age[k] + 1);
                end
            end
            if (acc) begin
                nd.push_back(int'(ISSUE_DEST));
                na.push_back(0);
            end
            m_dest = nd;
            m_age  = na;
        end
    endtask

    initial begin
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge CLK);
            model_step();
            #1;
            RST         = (cyc < 2) || ($urandom_range(0, 149) == 0);
            ISSUE_VALID = ($urandom_range(0, 3) != 0);
            ISSUE_WEN   = ($urandom_range(0, 4) != 0);
            ISSUE_DEST  = 5'($urandom_range(0, 7));
            SRC_A       = 5'($urandom_range(0, 7));
            SRC_B       = 5'($urandom_range(0, 7));
            SRC_A_USED  = ($urandom_range(0, 2) != 0);
            SRC_B_USED  = ($urandom_range(0, 2) != 0);
            FLUSH       = ($urandom_range(0, 19) == 0);
            #1;
            model_eval();
            chk("stall",     {31'd0, STALL},    {31'd0, e_stall});
            chk("pending",   PENDING,           e_pend);
            chk("wb_valid",  {31'd0, WB_VALID}, {31'd0, e_wbv});
            chk("wb_dest",   {27'd0, WB_DEST},  {27'd0, e_wbd});
            chk("wb_onehot", WB_ONEHOT,         e_oh);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
